// File: rtl/mmio_pkg.sv
// mmio_pkg -- shared definitions for the memory-mapped I/O interconnect.
//   busState_t      : bus controller states (IDLE / WAIT / RESP)
//   DEFAULT_ERR_DATA: load data returned on an unmapped access or timeout
//   *_BASE          : default channel windows for the board peripherals
//   onehot_lowest() : keeps only the lowest set bit of a match vector
package mmio_pkg;

    // Widest channel count the decoder supports.
    localparam int MAX_DEV = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } busState_t;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

    // Default peripheral windows, channel 0 upwards.
    localparam logic [31:0] HEX_BASE  = 32'hF0000000;
    localparam logic [31:0] LEDR_BASE = 32'hF0000004;
    localparam logic [31:0] KEY_BASE  = 32'hF0000010;
    localparam logic [31:0] SW_BASE   = 32'hF0000014;

    // Packed so that channel i occupies bits [i*32 +: 32].
    localparam logic [4*32-1:0] DEFAULT_DEV_BASE = {SW_BASE, KEY_BASE, LEDR_BASE, HEX_BASE};

    // Two's-complement trick: x & -x isolates the lowest set bit, which
    // gives the lowest-index-wins priority without a loop.
    function automatic logic [MAX_DEV-1:0] onehot_lowest(input logic [MAX_DEV-1:0] match);
        return match & (~match + 16'd1);
    endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// mmio_addr_decode -- combinational channel decoder.
//   addr : byte address of the request
//   hit  : at least one channel window matches
//   sel  : one-hot select of the lowest-index matching channel
// A channel matches when the masked address equals its masked base.
module mmio_addr_decode
    import mmio_pkg::*;
#(
    parameter int                     DBITS    = 32,
    parameter int                     NDEV     = 4,
    parameter logic [NDEV*DBITS-1:0]  DEV_BASE = DEFAULT_DEV_BASE,
    parameter logic [DBITS-1:0]       DEV_MASK = 32'hFFFFFFFC
) (
    input  logic [DBITS-1:0] addr,
    output logic             hit,
    output logic [NDEV-1:0]  sel
);

    logic [MAX_DEV-1:0] match;
    logic [MAX_DEV-1:0] first;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        match = '0;
        for (int i = 0; i < NDEV; i++) begin
            match[i] = (addr & DEV_MASK) == (DEV_BASE[i*DBITS +: DBITS] & DEV_MASK);
        end
    end

    assign first = onehot_lowest(match);
    assign sel   = first[NDEV-1:0];
    assign hit   = |first;

endmodule

// File: rtl/mmio_bus.sv
// mmio_bus -- memory-mapped I/O interconnect between the core load/store
// path and NDEV peripheral channels, with a registered request/response
// handshake, variable-latency device acknowledge and a bus timeout.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/req_we      : core request strobe, 1 = store
//   req_addr/req_wdata    : request byte address and store data
//   req_ready             : bus idle, request accepted on valid && ready
//   rsp_valid             : one-cycle response strobe
//   rsp_rdata/rsp_err     : load data (0 for stores) and error flag
//   dev_sel               : one-hot channel select, held until ack/timeout
//   dev_we/addr/wdata     : registered copy of the accepted request
//   dev_ack/dev_rdata     : per-channel completion and read data
//
// Build option: define MMIO_BUS_STATS_EN to map a statistics register
// {err_count, access_count} at STATS_ADDR (load reads, store clears).
module mmio_bus
    import mmio_pkg::*;
#(
    parameter int                     DBITS      = 32,
    parameter int                     NDEV       = 4,
    parameter logic [NDEV*DBITS-1:0]  DEV_BASE   = DEFAULT_DEV_BASE,
    parameter logic [DBITS-1:0]       DEV_MASK   = 32'hFFFFFFFC,
    parameter int                     TIMEOUT    = 16,
    parameter logic [DBITS-1:0]       ERR_DATA   = DEFAULT_ERR_DATA,
    parameter logic [DBITS-1:0]       STATS_ADDR = 32'hF00000F0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    input  logic                    req_we,
    input  logic [DBITS-1:0]        req_addr,
    input  logic [DBITS-1:0]        req_wdata,
    output logic                    req_ready,
    output logic                    rsp_valid,
    output logic [DBITS-1:0]        rsp_rdata,
    output logic                    rsp_err,
    output logic [NDEV-1:0]         dev_sel,
    output logic                    dev_we,
    output logic [DBITS-1:0]        dev_addr,
    output logic [DBITS-1:0]        dev_wdata,
    input  logic [NDEV-1:0]         dev_ack,
    input  logic [NDEV*DBITS-1:0]   dev_rdata
);

    localparam int              CNT_W     = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    busState_t          state;
    logic [CNT_W-1:0]   waitCount;
    logic               decHit;
    logic [NDEV-1:0]    decSel;
    logic [DBITS-1:0]   selData;
    logic               ackSeen;
    logic               statsHit;
    logic [DBITS-1:0]   statsValue;

    mmio_addr_decode #(
        .DBITS    (DBITS),
        .NDEV     (NDEV),
        .DEV_BASE (DEV_BASE),
        .DEV_MASK (DEV_MASK)
    ) u_decode (
        .addr (req_addr),
        .hit  (decHit),
        .sel  (decSel)
    );

    // Read data of the channel currently selected.
    always_comb begin
        selData = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (dev_sel[i]) selData = dev_rdata[i*DBITS +: DBITS];
        end
    end

    // Acks from channels other than the selected one are masked off here.
    assign ackSeen = |(dev_ack & dev_sel);

`ifdef MMIO_BUS_STATS_EN
    logic [15:0] accessCount;
    logic [15:0] errCount;
    logic        accessEvent;
    logic        errEvent;
    logic        clearEvent;

    assign statsHit    = (req_addr == STATS_ADDR);
    assign statsValue  = DBITS'({errCount, accessCount});
    assign clearEvent  = (state == IDLE) && req_valid && statsHit && req_we;
    assign accessEvent = (state == IDLE) && req_valid && !statsHit && decHit;
    assign errEvent    = ((state == IDLE) && req_valid && !statsHit && !decHit) ||
                         ((state == WAIT) && !ackSeen && (waitCount == LAST_WAIT));

    always_ff @(posedge clk) begin
        if (reset || clearEvent) begin
            accessCount <= '0;
            errCount    <= '0;
        end else begin
            if (accessEvent && accessCount != 16'hFFFF) accessCount <= accessCount + 16'd1;
            if (errEvent && errCount != 16'hFFFF)       errCount    <= errCount + 16'd1;
        end
    end
`else
    // No statistics register: STATS_ADDR decodes like any other address.
    assign statsHit   = 1'b0;
    assign statsValue = '0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            dev_sel   <= '0;
            dev_we    <= 1'b0;
            dev_addr  <= '0;
            dev_wdata <= '0;
            waitCount <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        dev_we    <= req_we;
                        dev_addr  <= req_addr;
                        dev_wdata <= req_wdata;
                        req_ready <= 1'b0;
                        if (statsHit) begin
                            // Served locally: straight to RESP, no channel.
                            rsp_err   <= 1'b0;
                            rsp_rdata <= req_we ? '0 : statsValue;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else if (decHit) begin
                            dev_sel   <= decSel;
                            waitCount <= '0;
                            state     <= WAIT;
                        end else begin
                            rsp_err   <= 1'b1;
                            rsp_rdata <= req_we ? '0 : ERR_DATA;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                WAIT: begin
                    // Ack is tested first so it wins over a same-cycle timeout.
                    if (ackSeen) begin
                        rsp_err   <= 1'b0;
                        rsp_rdata <= dev_we ? '0 : selData;
                        dev_sel   <= '0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (waitCount == LAST_WAIT) begin
                        rsp_err   <= 1'b1;
                        rsp_rdata <= dev_we ? '0 : ERR_DATA;
                        dev_sel   <= '0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        waitCount <= waitCount + 1'b1;
                    end
                end
                RESP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    dev_sel   <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_bus.sv
// tb_mmio_bus -- self-checking bench for mmio_bus: directed vector table,
// randomized accesses against a transaction-level model, reset in the
// middle of an access and (when built with MMIO_BUS_STATS_EN) the
// statistics register.
module tb_mmio_bus;

    localparam int          TIMEOUT = 16;
    localparam logic [31:0] MASK    = 32'hFFFFFFFC;
    localparam logic [31:0] ERR     = 32'hDEADBEEF;

    logic           clk = 1'b0;
    logic           reset;
    logic           req_valid;
    logic           req_we;
    logic [31:0]    req_addr;
    logic [31:0]    req_wdata;
    logic           req_ready;
    logic           rsp_valid;
    logic [31:0]    rsp_rdata;
    logic           rsp_err;
    logic [3:0]     dev_sel;
    logic           dev_we;
    logic [31:0]    dev_addr;
    logic [31:0]    dev_wdata;
    logic [3:0]     dev_ack;
    logic [127:0]   dev_rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] base [4] = '{32'hF0000000, 32'hF0000004, 32'hF0000010, 32'hF0000014};

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          delay;         // ack in WAIT cycle 'delay'; 0 = never
        logic [31:0] ackData;
        logic [3:0]  expSel;
        int          expLat;        // cycles from accept to rsp_valid
        logic        expErr;
        logic [31:0] expRdata;
        int          expSelCycles;
    } vec_t;

    mmio_bus dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .dev_sel   (dev_sel),
        .dev_we    (dev_we),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_ack   (dev_ack),
        .dev_rdata (dev_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                                input int delay, input logic [31:0] ackData, input logic [3:0] expSel,
                                input int expLat, input logic expErr, input logic [31:0] expRdata,
                                input int expSelCycles);
        vec_t v;
        v.addr = addr; v.we = we; v.wdata = wdata; v.delay = delay; v.ackData = ackData;
        v.expSel = expSel; v.expLat = expLat; v.expErr = expErr; v.expRdata = expRdata;
        v.expSelCycles = expSelCycles;
        return v;
    endfunction

    // Transaction-level reference: which window, how long, what comes back.
    function automatic vec_t model(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                                   input int delay, input logic [31:0] ackData);
        int ch = -1;
        for (int i = 0; i < 4; i++)
            if (ch < 0 && (addr & MASK) == (base[i] & MASK)) ch = i;
        if (ch < 0)
            return mk(addr, we, wdata, delay, ackData, 4'b0000, 1, 1'b1, we ? 32'h0 : ERR, 0);
        else if (delay >= 1 && delay <= TIMEOUT)
            return mk(addr, we, wdata, delay, ackData, 4'(1 << ch), delay + 1, 1'b0,
                      we ? 32'h0 : ackData, delay);
        else
            return mk(addr, we, wdata, 0, ackData, 4'(1 << ch), TIMEOUT + 1, 1'b1,
                      we ? 32'h0 : ERR, TIMEOUT);
    endfunction

    // Random acks on every channel except 'ch'; channel ch acks only when told.
    task automatic drive_acks(input int ch, input bit ackNow, input logic [31:0] data);
        logic [3:0] a;
        a = 4'($urandom);
        for (int i = 0; i < 4; i++) dev_rdata[i*32 +: 32] = $urandom;
        if (ch >= 0) begin
            a[ch] = ackNow;
            dev_rdata[ch*32 +: 32] = data;
        end
        dev_ack = a;
    endtask

    task automatic do_access(input vec_t v, input string tag);
        int ch = -1;
        int k;
        int lat = 0;
        int selCycles = 0;
        bit done = 0;
        bit heldBad = 0;
        bit readyBad = 0;
        logic [3:0] firstSel = '0;
        logic [31:0] keepData;
        logic keepErr;
        for (int i = 0; i < 4; i++) if (v.expSel[i]) ch = i;
        k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({tag, " ready_before"}, 32'(req_ready), 32'h1);
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        drive_acks(ch, 1'b0, v.ackData);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        check({tag, " dev_addr"}, dev_addr, v.addr);
        check({tag, " dev_we_wdata"}, {dev_we, dev_wdata[30:0]}, {v.we, v.wdata[30:0]});
        for (k = 1; k <= 40 && !done; k++) begin
            if (dev_sel != 4'b0000) begin
                selCycles++;
                if (firstSel == 4'b0000) firstSel = dev_sel;
                if (dev_we !== v.we || dev_addr !== v.addr || dev_wdata !== v.wdata) heldBad = 1;
            end
            if (req_ready) readyBad = 1;
            if (rsp_valid) begin
                lat  = k;
                done = 1;
            end else begin
                drive_acks(ch, k == v.delay, v.ackData);
                @(negedge clk);
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(v.expLat));
        check({tag, " rsp_err"}, 32'(rsp_err), 32'(v.expErr));
        check({tag, " rsp_rdata"}, rsp_rdata, v.expRdata);
        check({tag, " dev_sel"}, 32'(firstSel), 32'(v.expSel));
        check({tag, " sel_cycles"}, 32'(selCycles), 32'(v.expSelCycles));
        check({tag, " dev_held"}, 32'(heldBad), 32'h0);
        check({tag, " ready_low"}, 32'(readyBad), 32'h0);
        keepData = rsp_rdata;
        keepErr  = rsp_err;
        drive_acks(ch, 1'b0, v.ackData);
        @(negedge clk);
        check({tag, " rsp_one_cycle"}, {31'(rsp_valid), req_ready}, {31'h0, 1'b1});
        check({tag, " rsp_hold"}, {rsp_rdata[30:0], rsp_err}, {keepData[30:0], keepErr});
    endtask

    vec_t vecs [9];
    vec_t rv;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        dev_ack   = '0;
        dev_rdata = '0;

        //          addr          we    wdata         dly ackData       sel      lat err  rdata         selCyc
        vecs[0] = mk(32'hF0000010, 1'b0, 32'h0,        1,  32'h0000000A, 4'b0100, 2,  1'b0, 32'h0000000A, 1);
        vecs[1] = mk(32'hF0000000, 1'b1, 32'h00001234, 5,  32'h55555555, 4'b0001, 6,  1'b0, 32'h00000000, 5);
        vecs[2] = mk(32'hF0000100, 1'b0, 32'h0,        0,  32'h0,        4'b0000, 1,  1'b1, 32'hDEADBEEF, 0);
        vecs[3] = mk(32'hF0000004, 1'b0, 32'h0,        0,  32'h12345678, 4'b0010, 17, 1'b1, 32'hDEADBEEF, 16);
        vecs[4] = mk(32'hF0000200, 1'b1, 32'hCAFEF00D, 0,  32'h0,        4'b0000, 1,  1'b1, 32'h00000000, 0);
        vecs[5] = mk(32'hF0000016, 1'b0, 32'h0,        16, 32'hA5A5A5A5, 4'b1000, 17, 1'b0, 32'hA5A5A5A5, 16);
        vecs[6] = mk(32'hF0000013, 1'b0, 32'h0,        3,  32'h0BADF00D, 4'b0100, 4,  1'b0, 32'h0BADF00D, 3);
        vecs[7] = mk(32'hF0000014, 1'b1, 32'h00000077, 0,  32'h0,        4'b1000, 17, 1'b1, 32'h00000000, 16);
        vecs[8] = mk(32'hF0000008, 1'b0, 32'h0,        2,  32'h0,        4'b0000, 1,  1'b1, 32'hDEADBEEF, 0);

        repeat (3) @(negedge clk);
        check("reset handshake", {29'h0, req_ready, rsp_valid, rsp_err}, 32'h4);
        check("reset rsp_rdata", rsp_rdata, 32'h0);
        check("reset dev_sel_we", {27'h0, dev_sel, dev_we}, 32'h0);
        check("reset dev_addr", dev_addr, 32'h0);
        check("reset dev_wdata", dev_wdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) do_access(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 30; i++) begin
            int mode;
            logic [31:0] a;
            mode = $urandom_range(0, 4);
            if (mode < 4) a = base[mode] | 32'($urandom_range(0, 3));
            else          a = 32'hF0000100 + (32'($urandom_range(0, 255)) << 2);
            rv = model(a, 1'($urandom), $urandom, $urandom_range(0, 18), $urandom);
            do_access(rv, $sformatf("rnd%0d", i));
        end

        // Reset during WAIT cycle 3 of a never-acked load, then a late ack.
        begin
            bit sawRsp = 0;
            bit sawSel = 0;
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_addr  = 32'hF0000000;
            dev_ack   = '0;
            @(negedge clk);
            req_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check("midreset dev_sel", 32'(dev_sel), 32'h0);
            check("midreset ready_valid", {30'h0, req_ready, rsp_valid}, 32'h2);
            dev_ack = 4'b1111;
            repeat (4) begin
                @(negedge clk);
                if (rsp_valid) sawRsp = 1;
                if (dev_sel != 4'b0000) sawSel = 1;
            end
            dev_ack = '0;
            check("midreset no_rsp", {30'h0, sawRsp, sawSel}, 32'h0);
            do_access(mk(32'hF0000004, 1'b1, 32'h0000BEEF, 2, 32'h0, 4'b0010, 3, 1'b0, 32'h0, 2),
                      "after_reset");
        end

`ifdef MMIO_BUS_STATS_EN
        begin
            vec_t sv [7];
            sv[0] = mk(32'hF00000F0, 1'b1, 32'h0, 0, 32'h0,        4'b0000, 1, 1'b0, 32'h00000000, 0);
            sv[1] = mk(32'hF0000000, 1'b0, 32'h0, 1, 32'h00000011, 4'b0001, 2, 1'b0, 32'h00000011, 1);
            sv[2] = mk(32'hF0000004, 1'b1, 32'h5, 2, 32'h0,        4'b0010, 3, 1'b0, 32'h00000000, 2);
            sv[3] = mk(32'hF0000010, 1'b0, 32'h0, 1, 32'h00000033, 4'b0100, 2, 1'b0, 32'h00000033, 1);
            sv[4] = mk(32'hF0000300, 1'b0, 32'h0, 0, 32'h0,        4'b0000, 1, 1'b1, 32'hDEADBEEF, 0);
            sv[5] = mk(32'hF00000F0, 1'b0, 32'h0, 0, 32'h0,        4'b0000, 1, 1'b0, 32'h00010003, 0);
            sv[6] = mk(32'hF00000F0, 1'b1, 32'h0, 0, 32'h0,        4'b0000, 1, 1'b0, 32'h00000000, 0);
            for (int i = 0; i < 7; i++) do_access(sv[i], $sformatf("stats%0d", i));
            do_access(mk(32'hF00000F0, 1'b0, 32'h0, 0, 32'h0, 4'b0000, 1, 1'b0, 32'h00000000, 0),
                      "stats_cleared");
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
